alu_writeback_stage: RTL

- Writeback stage directly downstream of the two ALU pipes.
- Each cycle it accepts up to two completed ALU results (slot 0 older, slot 1 younger) and commits them in program order to the architectural GPR file (8 x 32-bit) and the arithmetic flags.
- Merges x86 partial-register writes (AL/AH/AX/EAX forms).
- Provides bypassed read ports for the upstream operand-fetch stage, plus registered retire status and a retire counter.

---
 rtl/alu_writeback_stage_pkg.sv | 74 +++++++
 rtl/alu_writeback_stage_if.sv | 30 +++
 rtl/alu_writeback_stage_gpr_merge_unit.sv | 41 ++++
 rtl/alu_writeback_stage.sv | 80 ++++++++
 4 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and the partial-register merge helper for the ALU writeback stage.
// merge_partial is also used by operand-bypass logic elsewhere, so it stays pure.
package alu_writeback_stage_pkg;

  localparam int NUM_GPR = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_RSVD  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } wb_size_t;

  typedef struct packed {
    logic OF;
    logic SF;
    logic ZF;
    logic AF;
    logic PF;
    logic CF;
  } flags_t;

  typedef struct packed {
    logic        valid;
    logic        wr_reg;
    logic [2:0]  dst;
    wb_size_t    size;
    logic [31:0] result;
    logic        wr_flags;
    flags_t      flags;
  } wb_slot_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] value;
    logic [3:0]  be;
  } merge_res_t;

  // Byte encodings 4-7 (AH/CH/DH/BH) alias the high byte of registers 0-3.
  function automatic logic [2:0] gpr_index(logic [2:0] dst, wb_size_t size);
    return (size == SZ_BYTE) ? {1'b0, dst[1:0]} : dst;
  endfunction

  // old must be the current value of register gpr_index(dst, size).
  function automatic merge_res_t merge_partial(logic [31:0] old, logic [2:0] dst,
                                               wb_size_t size, logic [31:0] result);
    merge_res_t r;
    r.idx   = gpr_index(dst, size);
    r.value = old;
    r.be    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        if (dst[2]) begin
          r.value[15:8] = result[7:0];
          r.be          = 4'b0010;
        end else begin
          r.value[7:0] = result[7:0];
          r.be         = 4'b0001;
        end
      end
      SZ_WORD: begin
        r.value[15:0] = result[15:0];
        r.be          = 4'b0011;
      end
      SZ_DWORD: begin
        r.value = result;
        r.be    = 4'b1111;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Writeback bus from the two ALU pipes plus operand read ports and retire status.
interface alu_writeback_stage_if #(
  parameter int NUM_RD = 4,
  parameter int CNT_W  = 32
);
  logic [1:0]              wb_valid;
  logic [1:0]              wb_wr_reg;
  logic [1:0][2:0]         wb_dst;
  logic [1:0][1:0]         wb_size;
  logic [1:0][31:0]        wb_result;
  logic [1:0]              wb_wr_flags;
  logic [1:0][5:0]         wb_flags;
  logic [NUM_RD-1:0][2:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_data;
  logic [5:0]              flags_out;
  logic                    commit_valid;
  logic [1:0]              commit_count;
  logic [CNT_W-1:0]        retire_count;
  logic                    size_err;

  modport master (
    output wb_valid, wb_wr_reg, wb_dst, wb_size, wb_result, wb_wr_flags, wb_flags, rd_addr,
    input  rd_data, flags_out, commit_valid, commit_count, retire_count, size_err
  );

  modport slave (
    input  wb_valid, wb_wr_reg, wb_dst, wb_size, wb_result, wb_wr_flags, wb_flags, rd_addr,
    output rd_data, flags_out, commit_valid, commit_count, retire_count, size_err
  );
endinterface

// File: rtl/alu_writeback_stage_gpr_merge_unit.sv
// Ordered two-slot merge: slot 1 is layered on top of slot 0. Feeds both the
// register update and the bypass reads so commit and forward always agree.
module gpr_merge_unit
  import alu_writeback_stage_pkg::*;
(
  input  logic [NUM_GPR-1:0][31:0] gpr_i,
  input  flags_t                   flags_i,
  input  wb_slot_t [1:0]           slots_i,
  output logic [NUM_GPR-1:0][31:0] gpr_o,
  output flags_t                   flags_o,
  output logic                     rsvd_o
);

  logic [NUM_GPR-1:0][31:0] g;
  flags_t                   f;
  merge_res_t               m;

  always_comb begin
    g      = gpr_i;
    f      = flags_i;
    m      = '0;
    rsvd_o = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (slots_i[s].valid && slots_i[s].wr_reg) begin
        if (slots_i[s].size == SZ_RSVD) begin
          rsvd_o = 1'b1;
        end else begin
          m = merge_partial(g[gpr_index(slots_i[s].dst, slots_i[s].size)],
                            slots_i[s].dst, slots_i[s].size, slots_i[s].result);
          g[m.idx] = m.value;
        end
      end
      if (slots_i[s].valid && slots_i[s].wr_flags) begin
        f = slots_i[s].flags;
      end
    end
    gpr_o   = g;
    flags_o = f;
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage: commits up to two ALU results per cycle in program order,
// forwards post-commit values to the read ports, and tracks retire status.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int NUM_RD = 4,
  parameter int CNT_W  = 32
) (
  input logic                  clk,
  input logic                  reset,
  alu_writeback_stage_if.slave wb
);

  logic [NUM_GPR-1:0][31:0] gpr_q, gpr_d;
  flags_t                   flags_q, flags_d;
  wb_slot_t [1:0]           slots;
  logic                     rsvd;
  logic [1:0]               commit_sum;
  logic                     commit_valid_q;
  logic [1:0]               commit_count_q;
  logic [CNT_W-1:0]         retire_q;
  logic                     size_err_q;

  always_comb begin
    slots = '0;
    for (int s = 0; s < 2; s++) begin
      slots[s].valid    = wb.wb_valid[s];
      slots[s].wr_reg   = wb.wb_wr_reg[s];
      slots[s].dst      = wb.wb_dst[s];
      slots[s].size     = wb_size_t'(wb.wb_size[s]);
      slots[s].result   = wb.wb_result[s];
      slots[s].wr_flags = wb.wb_wr_flags[s];
      slots[s].flags    = flags_t'(wb.wb_flags[s]);
    end
  end

  gpr_merge_unit u_merge (
    .gpr_i   (gpr_q),
    .flags_i (flags_q),
    .slots_i (slots),
    .gpr_o   (gpr_d),
    .flags_o (flags_d),
    .rsvd_o  (rsvd)
  );

  assign commit_sum = {1'b0, wb.wb_valid[0]} + {1'b0, wb.wb_valid[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_q          <= '0;
      flags_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_count_q <= 2'd0;
      retire_q       <= '0;
      size_err_q     <= 1'b0;
    end else begin
      gpr_q          <= gpr_d;
      flags_q        <= flags_d;
      commit_valid_q <= (commit_sum != 2'd0);
      commit_count_q <= commit_sum;
      retire_q       <= retire_q + CNT_W'(commit_sum);
      size_err_q     <= size_err_q | rsvd;
    end
  end

  // Reads see this cycle's pending writes, not just the stored file.
  always_comb begin
    wb.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      wb.rd_data[i] = gpr_d[wb.rd_addr[i]];
    end
  end

  assign wb.flags_out    = flags_d;
  assign wb.commit_valid = commit_valid_q;
  assign wb.commit_count = commit_count_q;
  assign wb.retire_count = retire_q;
  assign wb.size_err     = size_err_q;

endmodule
